// File: rtl/bram_arbiter_pkg.sv
// Shared types and defaults for the two-requester BRAM arbiter.
package bram_arbiter_pkg;

   localparam int ADDR_SZ_DEF = 8;
   localparam int DATA_SZ_DEF = 16;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } who_e;

   typedef struct packed {
      logic vld;
      who_e who;
   } tag_t;

endpackage

// File: rtl/bram_arbiter_arb2_rr.sv
// Two-way arbiter: round-robin on contention, or A-first when FIXED_PRI.
module arb2_rr
   import bram_arbiter_pkg::*;
#(
   parameter int FIXED_PRI = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   who_e prio_q, prio_d;

   always_comb begin
      o_gnt  = 2'b00;
      prio_d = prio_q;
      unique case (1'b1)
         (i_req == 2'b01): o_gnt = 2'b01;
         (i_req == 2'b10): o_gnt = 2'b10;
         (i_req == 2'b11): begin
            if (FIXED_PRI != 0 || prio_q == REQ_A)
               o_gnt = 2'b01;
            else
               o_gnt = 2'b10;
         end
         default: ;
      endcase
      // pointer moves only on a grant, to the side not just served
      if (o_gnt[0])
         prio_d = REQ_B;
      else if (o_gnt[1])
         prio_d = REQ_A;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         prio_q <= REQ_A;
      else
         prio_q <= prio_d;
   end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one registered-read BRAM between requesters A and B; one op per cycle.
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int ADDR_SZ   = ADDR_SZ_DEF,
   parameter int DATA_SZ   = DATA_SZ_DEF,
   parameter int FIXED_PRI = 0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_a_req,
   input  logic               i_a_wr,
   input  logic [ADDR_SZ-1:0] i_a_addr,
   input  logic [DATA_SZ-1:0] i_a_wdata,
   output logic               o_a_gnt,
   output logic               o_a_rvalid,
   input  logic               i_b_req,
   input  logic               i_b_wr,
   input  logic [ADDR_SZ-1:0] i_b_addr,
   input  logic [DATA_SZ-1:0] i_b_wdata,
   output logic               o_b_gnt,
   output logic               o_b_rvalid,
   output logic [DATA_SZ-1:0] o_rdata,
   output logic               o_wr_en,
   output logic [ADDR_SZ-1:0] o_waddr,
   output logic [DATA_SZ-1:0] o_wdata,
   output logic               o_rd_en,
   output logic [ADDR_SZ-1:0] o_raddr,
   input  logic [DATA_SZ-1:0] i_rdata
);

   logic [1:0]         req, gnt;
   op_e                sel_op;
   who_e               sel_who;
   logic [ADDR_SZ-1:0] sel_addr;
   logic [DATA_SZ-1:0] sel_wdata;

   logic               wr_en_q, wr_en_d;
   logic               rd_en_q, rd_en_d;
   logic [ADDR_SZ-1:0] waddr_q, waddr_d;
   logic [ADDR_SZ-1:0] raddr_q, raddr_d;
   logic [DATA_SZ-1:0] wdata_q, wdata_d;
   tag_t               tag1_q, tag1_d;
   tag_t               tag2_q, tag2_d;

   // no op may be accepted while reset holds the command register
   assign req = {i_b_req, i_a_req} & {2{~i_rst}};

   arb2_rr #(
      .FIXED_PRI(FIXED_PRI)
   ) u_arb (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_req(req),
      .o_gnt(gnt)
   );

   always_comb begin
      sel_op    = OP_RD;
      sel_who   = REQ_A;
      sel_addr  = '0;
      sel_wdata = '0;
      unique case (1'b1)
         gnt[0]: begin
            sel_op    = op_e'(i_a_wr);
            sel_who   = REQ_A;
            sel_addr  = i_a_addr;
            sel_wdata = i_a_wdata;
         end
         gnt[1]: begin
            sel_op    = op_e'(i_b_wr);
            sel_who   = REQ_B;
            sel_addr  = i_b_addr;
            sel_wdata = i_b_wdata;
         end
         default: ;
      endcase

      wr_en_d = (|gnt) && (sel_op == OP_WR);
      rd_en_d = (|gnt) && (sel_op == OP_RD);
      waddr_d = wr_en_d ? sel_addr  : waddr_q;
      wdata_d = wr_en_d ? sel_wdata : wdata_q;
      raddr_d = rd_en_d ? sel_addr  : raddr_q;
      tag1_d  = '{vld: rd_en_d, who: sel_who};
      tag2_d  = tag1_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         raddr_q <= '0;
         tag1_q  <= '0;
         tag2_q  <= '0;
      end else begin
         wr_en_q <= wr_en_d;
         rd_en_q <= rd_en_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         raddr_q <= raddr_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag2_d;
      end
   end

   assign o_a_gnt    = gnt[0];
   assign o_b_gnt    = gnt[1];
   assign o_wr_en    = wr_en_q;
   assign o_rd_en    = rd_en_q;
   assign o_waddr    = waddr_q;
   assign o_wdata    = wdata_q;
   assign o_raddr    = raddr_q;
   assign o_rdata    = i_rdata;
   assign o_a_rvalid = tag2_q.vld && (tag2_q.who == REQ_A);
   assign o_b_rvalid = tag2_q.vld && (tag2_q.who == REQ_B);

endmodule
